// File: rtl/switch_input_ctrl.sv
// ----------------------------------------------------------------------------
// switch_input_ctrl
// Slide-switch input controller for the Nios CPU. Every switch bit is brought
// into the clk domain by a two-flop synchroniser and then debounced on its own
// counter. Accepted (debounced) edges are latched in EDGE_CAPTURE and raise a
// maskable level interrupt. Firmware accesses the block through a 4-word
// Avalon-MM slave that has no wait states.
//
//   0 DATA          debounced levels            (read-only)
//   1 RAW           synchronised raw levels     (read-only, diagnostics)
//   2 IRQ_MASK      interrupt enable per bit    (read/write)
//   3 EDGE_CAPTURE  latched edges               (read, write-1-to-clear)
// ----------------------------------------------------------------------------
module switch_input_ctrl #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_RAW   = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;
  localparam logic [1:0] ADDR_EDGE  = 2'd3;

  // Synchroniser, debounce and register state
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] edge_d;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;
  logic             irq_q;
  logic             irq_d;

  // Bus decode helpers
  logic             wr_s;
  logic [WIDTH-1:0] wdata_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] set_s;

  assign wr_s    = chipselect & ~write_n;
  assign wdata_s = writedata[WIDTH-1:0];

  // Upper write-data bits carry no meaning for narrow switch banks
  generate
    if (WIDTH < 32) begin : g_unused_wdata
      logic unused_wdata_s;
      assign unused_wdata_s = ^writedata[31:WIDTH];
    end
  endgenerate

  // Two-stage synchroniser: the only consumer of the asynchronous in_port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= {WIDTH{1'b0}};
      sync_q  <= {WIDTH{1'b0}};
    end else begin
      sync1_q <= in_port;
      sync_q  <= sync1_q;
    end
  end

  // Per-bit debounce: a new level must persist DEBOUNCE_CYCLES cycles
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = CNT_ZERO;
      if (sync_q[i] == stable_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync_q[i];
        cnt_d[i]    = CNT_ZERO;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Debounce state registers; reset discards any partially counted change
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Edge detection on debounced levels, W1C clear, mask write and irq
  always_comb begin
    rise_s = stable_d & ~stable_q;
    fall_s = ~stable_d & stable_q;
    case (EDGE_TYPE)
      0:       set_s = rise_s;
      1:       set_s = fall_s;
      default: set_s = rise_s | fall_s;
    endcase
    if (wr_s && (address == ADDR_EDGE)) begin
      clr_s = wdata_s;
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
    if (wr_s && (address == ADDR_MASK)) begin
      mask_d = wdata_s;
    end else begin
      mask_d = mask_q;
    end
    // A capture on the same edge as its clear wins
    edge_d = (edge_q & ~clr_s) | set_s;
    irq_d  = |(edge_d & mask_d);
  end

  // Read mux: readdata is refreshed every cycle from the current address
  always_comb begin
    readdata_d = 32'h0000_0000;
    case (address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = stable_q;
      ADDR_RAW:  readdata_d[WIDTH-1:0] = sync_q;
      ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_q;
      default:   readdata_d = 32'h0000_0000;
    endcase
  end

  // Register file and registered bus outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_q     <= {WIDTH{1'b0}};
      mask_q     <= {WIDTH{1'b0}};
      readdata_q <= 32'h0000_0000;
      irq_q      <= 1'b0;
    end else begin
      edge_q     <= edge_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_switch_input_ctrl.sv
// ----------------------------------------------------------------------------
// Directed bench for switch_input_ctrl with WIDTH=10, DEBOUNCE_CYCLES=4,
// EDGE_TYPE=2. Inputs change 1 time unit after a rising edge and outputs are
// sampled at the same point, so each tick() is exactly one active edge.
// ----------------------------------------------------------------------------
module tb_switch_input_ctrl;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [9:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_assert;
  int n_fail;

  switch_input_ctrl #(
    .WIDTH           (10),
    .DEBOUNCE_CYCLES (4),
    .EDGE_TYPE       (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0000_0000;
  endtask

  task automatic do_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  initial begin
    logic [31:0] rd;
    n_assert   = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0000_0000;
    in_port    = 10'h3FF;

    // 1. Reset with all switches high, then re-qualification after release
    #25;
    check("rst_readdata", readdata, 32'h0000_0000);
    check("rst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    ticks(6);
    check("rst_data_edge6", readdata, 32'h0000_0000);
    tick();
    check("rst_data_edge7", readdata, 32'h0000_03FF);
    do_read(2'd3, rd);
    check("rst_edge_capture", rd, 32'h0000_03FF);
    check("rst_irq_masked", {31'd0, irq}, 32'd0);
    in_port = 10'h000;
    ticks(8);
    do_write(2'd3, 32'h0000_03FF);
    do_read(2'd3, rd);
    check("w1c_all", rd, 32'h0000_0000);
    do_read(2'd0, rd);
    check("data_low", rd, 32'h0000_0000);

    // 2. Glitch rejection, then a qualifying 4-cycle level
    in_port = 10'h008;
    ticks(3);
    in_port = 10'h000;
    ticks(6);
    do_read(2'd0, rd);
    check("glitch_data", rd, 32'h0000_0000);
    do_read(2'd3, rd);
    check("glitch_edge", rd, 32'h0000_0000);
    address = 2'd0;
    in_port = 10'h008;
    ticks(6);
    check("qual_data_edge6", readdata, 32'h0000_0000);
    tick();
    check("qual_data_edge7", readdata, 32'h0000_0008);
    do_read(2'd3, rd);
    check("qual_edge", rd, 32'h0000_0008);

    // 3. Interrupt path
    do_write(2'd3, 32'h0000_0008);
    do_write(2'd2, 32'h0000_0008);
    check("irq_after_mask", {31'd0, irq}, 32'd0);
    in_port = 10'h000;
    ticks(5);
    check("irq_edge5", {31'd0, irq}, 32'd0);
    tick();
    check("irq_edge6", {31'd0, irq}, 32'd1);
    do_write(2'd3, 32'h0000_0000);
    check("irq_w0_keeps", {31'd0, irq}, 32'd1);
    do_write(2'd3, 32'h0000_0008);
    check("irq_w1c_drops", {31'd0, irq}, 32'd0);

    // 4. W1C on the same edge bit 0 qualifies: the capture wins
    do_write(2'd2, 32'h0000_0009);
    in_port = 10'h001;
    ticks(5);
    check("coll_irq_pre", {31'd0, irq}, 32'd0);
    do_write(2'd3, 32'h0000_0001);
    check("coll_irq", {31'd0, irq}, 32'd1);
    do_read(2'd3, rd);
    check("coll_edge", rd, 32'h0000_0001);
    do_write(2'd3, 32'h0000_0001);
    check("coll_clear_irq", {31'd0, irq}, 32'd0);

    // 5. Register access: mask width, read-only words, RAW timing
    do_write(2'd2, 32'hFFFF_FFFF);
    do_read(2'd2, rd);
    check("mask_width", rd, 32'h0000_03FF);
    do_write(2'd0, 32'hFFFF_FFFF);
    do_write(2'd1, 32'hFFFF_FFFF);
    do_read(2'd0, rd);
    check("ro_data", rd, 32'h0000_0001);
    do_read(2'd2, rd);
    check("ro_mask_kept", rd, 32'h0000_03FF);
    address = 2'd1;
    in_port = 10'h2A0;
    ticks(2);
    check("raw_edge2", readdata, 32'h0000_0001);
    tick();
    check("raw_edge3", readdata, 32'h0000_02A0);
    do_read(2'd0, rd);
    check("raw_no_debounce", rd, 32'h0000_0001);

    // 6. Reset while bit 5 is mid-debounce
    ticks(10);
    in_port = 10'h000;
    ticks(10);
    do_write(2'd3, 32'h0000_03FF);
    address = 2'd2;
    in_port = 10'h020;
    ticks(4);
    check("pre_rst2_mask", readdata, 32'h0000_03FF);
    reset_n = 1'b0;
    #1;
    check("rst2_readdata", readdata, 32'h0000_0000);
    check("rst2_irq", {31'd0, irq}, 32'd0);
    tick();
    reset_n = 1'b1;
    address = 2'd3;
    ticks(5);
    check("rst2_edge5", readdata, 32'h0000_0000);
    tick();
    check("rst2_edge6", readdata, 32'h0000_0000);
    tick();
    check("rst2_edge7", readdata, 32'h0000_0020);
    check("rst2_irq_masked", {31'd0, irq}, 32'd0);
    do_read(2'd2, rd);
    check("rst2_mask", rd, 32'h0000_0000);
    do_read(2'd0, rd);
    check("rst2_data", rd, 32'h0000_0020);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
